ray_march_core: RTL and testbench

Parametrised ray-marching engine, successor to the single-cycle ray unit. Accepts an already-generated ray (origin, normalised direction, pixel coordinates) over a valid/ready handshake. Marches it against an external, variable-latency SDF evaluator through a request/response port. Returns a shaded pixel over a backpressurable valid/ready output. Several instances sit between the ray generator and the framebuffer writer; the SDF port makes the core fractal-agnostic.

---
 rtl/ray_march_core_pkg.sv | 84 ++++++++
 rtl/ray_march_core_march_step.sv | 14 +
 rtl/ray_march_core.sv | 200 ++++++++++++++++++++
 tb/tb_ray_march_core.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_march_core_pkg.sv
// ray_march_core_pkg: shared Q16.16 fixed-point types, march FSM states and
// saturating vector helpers used by the ray-march core and its step unit.
package ray_march_core_pkg;

   localparam int FP_BITS = 32;
   localparam int FP_FRAC = 16;

   typedef logic signed [FP_BITS-1:0] fp;

   typedef struct packed {
      fp x;
      fp y;
      fp z;
   } vec3;

   typedef enum logic [1:0] {
      RM_Idle = 2'd0,
      RM_Req  = 2'd1,
      RM_Wait = 2'd2,
      RM_Done = 2'd3
   } RayMarchState;

   // Fixed-point constants in the shared Q16.16 format
   localparam fp FP_ONE       = 32'sh0001_0000;
   localparam fp FP_FIVE      = FP_ONE * 5;
   localparam fp FP_HUNDREDTH = 32'sd655;

   // Default geometry of the pipeline this core sits in
   localparam int H_BITS_DEF    = 11;
   localparam int V_BITS_DEF    = 10;
   localparam int MAX_RAY_DEPTH = 16;

   localparam logic signed [63:0] FP_MAX_W = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] FP_MIN_W = 64'shFFFF_FFFF_8000_0000;

   // Clamp a wide intermediate back into the fp range
   function automatic fp fp_sat(input logic signed [63:0] v);
      if (v > FP_MAX_W) begin
         return 32'sh7FFF_FFFF;
      end else if (v < FP_MIN_W) begin
         return 32'sh8000_0000;
      end else begin
         return v[FP_BITS-1:0];
      end
   endfunction

   function automatic logic fp_lt(input fp a, input fp b);
      return a < b;
   endfunction

   function automatic logic fp_gt(input fp a, input fp b);
      return a > b;
   endfunction

   function automatic fp fp_add(input fp a, input fp b);
      logic signed [63:0] s;
      s = $signed({{32{a[FP_BITS-1]}}, a}) + $signed({{32{b[FP_BITS-1]}}, b});
      return fp_sat(s);
   endfunction

   // Truncating multiply: product shifted back by the fraction width, no rounding
   function automatic fp fp_mul(input fp a, input fp b);
      logic signed [63:0] p;
      p = $signed({{32{a[FP_BITS-1]}}, a}) * $signed({{32{b[FP_BITS-1]}}, b});
      return fp_sat(p >>> FP_FRAC);
   endfunction

   function automatic vec3 vec3_scaled(input vec3 v, input fp t);
      vec3 r;
      r.x = fp_mul(v.x, t);
      r.y = fp_mul(v.y, t);
      r.z = fp_mul(v.z, t);
      return r;
   endfunction

   function automatic vec3 vec3_add(input vec3 a, input vec3 b);
      vec3 r;
      r.x = fp_add(a.x, b.x);
      r.y = fp_add(a.y, b.y);
      r.z = fp_add(a.z, b.z);
      return r;
   endfunction

endpackage

// File: rtl/ray_march_core_march_step.sv
// march_step: combinational advance of a ray point, origin + direction * t,
// using the saturating vec3 helpers.
import ray_march_core_pkg::*;

module march_step (
   input  vec3 origin_in,
   input  vec3 direction_in,
   input  fp   t_in,
   output vec3 origin_out
);

   assign origin_out = vec3_add(origin_in, vec3_scaled(direction_in, t_in));

endmodule

// File: rtl/ray_march_core.sv
// ray_march_core: marches one ray at a time against an external SDF evaluator
// (one request outstanding) and returns a shaded pixel with hit flag and step
// count over a valid/ready output.
// Optional build macro RAY_MARCH_STATS_EN adds rays_done_out / hits_done_out
// handshake counters.
import ray_march_core_pkg::*;

module ray_march_core #(
   parameter int H_BITS      = H_BITS_DEF,
   parameter int V_BITS      = V_BITS_DEF,
   parameter int MAX_STEPS   = MAX_RAY_DEPTH,
   parameter fp  HIT_EPS     = FP_HUNDREDTH >>> 1,
   parameter fp  FAR_DIST    = FP_FIVE,
   parameter int COLOR_BITS  = 4,
   parameter int SHADE_SHIFT = 1
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           valid_in,
   output logic                           ready_out,
   input  vec3                            ray_origin_in,
   input  vec3                            ray_direction_in,
   input  logic [H_BITS-1:0]              hcount_in,
   input  logic [V_BITS-1:0]              vcount_in,
   output logic                           sdf_valid_out,
   output vec3                            sdf_point_out,
   input  logic                           sdf_valid_in,
   input  fp                              sdf_dist_in,
   output logic                           valid_out,
   input  logic                           ready_in,
   output logic [H_BITS-1:0]              hcount_out,
   output logic [V_BITS-1:0]              vcount_out,
   output logic [COLOR_BITS-1:0]          color_out,
   output logic                           hit_out,
   output logic [$clog2(MAX_STEPS+1)-1:0] steps_out
`ifdef RAY_MARCH_STATS_EN
   ,
   output logic [31:0]                    rays_done_out,
   output logic [31:0]                    hits_done_out
`endif
);

   localparam int STEP_W    = $clog2(MAX_STEPS + 1);
   localparam int COLOR_MAX = (1 << COLOR_BITS) - 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
   localparam logic [STEP_W-1:0] ALL_STEPS = STEP_W'(MAX_STEPS);

   RayMarchState            state_q, state_d;
   vec3                     origin_q, origin_d;
   vec3                     dir_q, dir_d;
   logic [H_BITS-1:0]       hcount_q, hcount_d;
   logic [V_BITS-1:0]       vcount_q, vcount_d;
   logic [STEP_W-1:0]       step_q, step_d;
   logic                    hit_q, hit_d;
   logic [COLOR_BITS-1:0]   color_q, color_d;
   logic [STEP_W-1:0]       steps_q, steps_d;

   vec3                     next_origin;
   logic [STEP_W-1:0]       step_shr;
   logic [COLOR_BITS-1:0]   hit_color;

   march_step u_march_step (
      .origin_in    (origin_q),
      .direction_in (dir_q),
      .t_in         (sdf_dist_in),
      .origin_out   (next_origin)
   );

   // Nearer hits (fewer steps) shade brighter; deep hits clamp to black
   assign step_shr  = step_q >> SHADE_SHIFT;
   assign hit_color = (int'(step_shr) >= COLOR_MAX) ? '0
                    : COLOR_BITS'(COLOR_MAX - int'(step_shr));

   assign ready_out     = (state_q == RM_Idle);
   assign sdf_valid_out = (state_q == RM_Req);
   assign sdf_point_out = origin_q;
   assign valid_out     = (state_q == RM_Done);
   assign hcount_out    = hcount_q;
   assign vcount_out    = vcount_q;
   assign color_out     = color_q;
   assign hit_out       = hit_q;
   assign steps_out     = steps_q;

   // Next-state and datapath updates; SDF responses only matter in RM_Wait
   always_comb begin
      state_d  = state_q;
      origin_d = origin_q;
      dir_d    = dir_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      step_d   = step_q;
      hit_d    = hit_q;
      color_d  = color_q;
      steps_d  = steps_q;
      case (state_q)
         RM_Idle: begin
            if (valid_in) begin
               origin_d = ray_origin_in;
               dir_d    = ray_direction_in;
               hcount_d = hcount_in;
               vcount_d = vcount_in;
               step_d   = '0;
               state_d  = RM_Req;
            end
         end
         RM_Req: begin
            state_d = RM_Wait;
         end
         RM_Wait: begin
            if (sdf_valid_in) begin
               if (fp_lt(sdf_dist_in, HIT_EPS)) begin
                  hit_d   = 1'b1;
                  steps_d = step_q + 1'b1;
                  color_d = hit_color;
                  state_d = RM_Done;
               end else if (fp_gt(sdf_dist_in, FAR_DIST)) begin
                  hit_d   = 1'b0;
                  steps_d = step_q + 1'b1;
                  color_d = '0;
                  state_d = RM_Done;
               end else if (step_q == LAST_STEP) begin
                  hit_d   = 1'b0;
                  steps_d = ALL_STEPS;
                  color_d = '0;
                  state_d = RM_Done;
               end else begin
                  origin_d = next_origin;
                  step_d   = step_q + 1'b1;
                  state_d  = RM_Req;
               end
            end
         end
         RM_Done: begin
            if (ready_in) begin
               state_d = RM_Idle;
            end
         end
         default: begin
            state_d = RM_Idle;
         end
      endcase
   end

   // State and datapath registers; reset abandons any ray in flight
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= RM_Idle;
         origin_q <= '0;
         dir_q    <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         step_q   <= '0;
         hit_q    <= 1'b0;
         color_q  <= '0;
         steps_q  <= '0;
      end else begin
         state_q  <= state_d;
         origin_q <= origin_d;
         dir_q    <= dir_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         step_q   <= step_d;
         hit_q    <= hit_d;
         color_q  <= color_d;
         steps_q  <= steps_d;
      end
   end

`ifdef RAY_MARCH_STATS_EN
   logic [31:0] rays_done_q, rays_done_d;
   logic [31:0] hits_done_q, hits_done_d;

   // Count completed output handshakes, and the hits among them (wrapping)
   always_comb begin
      rays_done_d = rays_done_q;
      hits_done_d = hits_done_q;
      if (valid_out && ready_in) begin
         rays_done_d = rays_done_q + 32'd1;
         if (hit_q) begin
            hits_done_d = hits_done_q + 32'd1;
         end
      end
   end

   // Statistics registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rays_done_q <= '0;
         hits_done_q <= '0;
      end else begin
         rays_done_q <= rays_done_d;
         hits_done_q <= hits_done_d;
      end
   end

   assign rays_done_out = rays_done_q;
   assign hits_done_out = hits_done_q;
`endif

endmodule

// File: tb/tb_ray_march_core.sv
// tb_ray_march_core: scoreboard bench for ray_march_core with an in-bench
// plane/table SDF mock of configurable latency.
import ray_march_core_pkg::*;

module tb_ray_march_core;

   localparam int H_BITS     = 11;
   localparam int V_BITS     = 10;
   localparam int MAX_STEPS  = 8;
   localparam int COLOR_BITS = 4;
   localparam int STEP_W     = 4;
   localparam fp  HALF       = 32'sd32768;
   localparam fp  EPS        = FP_HUNDREDTH >>> 1;

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic                  valid_in;
   logic                  ready_out;
   vec3                   ray_origin_in;
   vec3                   ray_direction_in;
   logic [H_BITS-1:0]     hcount_in;
   logic [V_BITS-1:0]     vcount_in;
   logic                  sdf_valid_out;
   vec3                   sdf_point_out;
   logic                  sdf_valid_in;
   fp                     sdf_dist_in;
   logic                  valid_out;
   logic                  ready_in;
   logic [H_BITS-1:0]     hcount_out;
   logic [V_BITS-1:0]     vcount_out;
   logic [COLOR_BITS-1:0] color_out;
   logic                  hit_out;
   logic [STEP_W-1:0]     steps_out;
`ifdef RAY_MARCH_STATS_EN
   logic [31:0]           rays_done_out;
   logic [31:0]           hits_done_out;
`endif

   ray_march_core #(
      .H_BITS      (H_BITS),
      .V_BITS      (V_BITS),
      .MAX_STEPS   (MAX_STEPS),
      .HIT_EPS     (EPS),
      .FAR_DIST    (FP_FIVE),
      .COLOR_BITS  (COLOR_BITS),
      .SHADE_SHIFT (1)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .valid_in         (valid_in),
      .ready_out        (ready_out),
      .ray_origin_in    (ray_origin_in),
      .ray_direction_in (ray_direction_in),
      .hcount_in        (hcount_in),
      .vcount_in        (vcount_in),
      .sdf_valid_out    (sdf_valid_out),
      .sdf_point_out    (sdf_point_out),
      .sdf_valid_in     (sdf_valid_in),
      .sdf_dist_in      (sdf_dist_in),
      .valid_out        (valid_out),
      .ready_in         (ready_in),
      .hcount_out       (hcount_out),
      .vcount_out       (vcount_out),
      .color_out        (color_out),
      .hit_out          (hit_out),
      .steps_out        (steps_out)
`ifdef RAY_MARCH_STATS_EN
      ,
      .rays_done_out    (rays_done_out),
      .hits_done_out    (hits_done_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int exp_rays = 0;
   int exp_hits = 0;

   typedef struct {
      logic [H_BITS-1:0]     h;
      logic [V_BITS-1:0]     v;
      logic                  hit;
      logic [STEP_W-1:0]     steps;
      logic [COLOR_BITS-1:0] color;
      vec3                   pt;
      int                    evals;
   } exp_t;
   exp_t sb_q[$];

   // ---------------- SDF mock (plane z=1.0 or a distance table) -------------
   int   mock_lat  = 3;
   int   mock_mode = 0;
   fp    mock_table [0:7];
   int   mock_base = 0;
   int   resp_cnt  = 0;
   int   mock_cnt  = 0;
   logic mock_valid = 1'b0;
   fp    mock_dist  = '0;
   logic spur_valid = 1'b0;
   fp    spur_dist  = '0;

   assign sdf_valid_in = mock_valid | spur_valid;
   assign sdf_dist_in  = spur_valid ? spur_dist : mock_dist;

   function automatic fp mock_eval(input vec3 p, input int idx);
      if (mock_mode == 0) begin
         return FP_ONE - p.z;
      end else begin
         return mock_table[(idx > 7) ? 7 : idx];
      end
   endfunction

   always @(posedge clk_in) begin
      mock_valid <= 1'b0;
      if (sdf_valid_out) begin
         if (mock_lat <= 1) begin
            mock_valid <= 1'b1;
            mock_dist  <= mock_eval(sdf_point_out, resp_cnt - mock_base);
            resp_cnt   <= resp_cnt + 1;
         end else begin
            mock_cnt <= mock_lat - 1;
         end
      end else if (mock_cnt != 0) begin
         mock_cnt <= mock_cnt - 1;
         if (mock_cnt == 1) begin
            mock_valid <= 1'b1;
            mock_dist  <= mock_eval(sdf_point_out, resp_cnt - mock_base);
            resp_cnt   <= resp_cnt + 1;
         end
      end
   end

   // ---------------- helpers -------------------------------------------------
   function automatic vec3 mkv(input fp x, input fp y, input fp z);
      vec3 r;
      r.x = x;
      r.y = y;
      r.z = z;
      return r;
   endfunction

   task automatic set_table(input fp first, input int n_first, input fp rest);
      mock_mode = 1;
      for (int i = 0; i < 8; i++) begin
         mock_table[i] = (i < n_first) ? first : rest;
      end
      mock_base = resp_cnt;
   endtask

   task automatic push_exp(input logic [H_BITS-1:0] h, input logic [V_BITS-1:0] v,
                           input logic hit, input int steps, input int color,
                           input vec3 pt, input int evals);
      exp_t e;
      e.h     = h;
      e.v     = v;
      e.hit   = hit;
      e.steps = STEP_W'(steps);
      e.color = COLOR_BITS'(color);
      e.pt    = pt;
      e.evals = evals;
      sb_q.push_back(e);
   endtask

   task automatic send_ray(input logic [H_BITS-1:0] h, input logic [V_BITS-1:0] v,
                           input vec3 o, input vec3 d);
      int n;
      n = 0;
      while (ready_out !== 1'b1 && n < 100) begin
         @(posedge clk_in); #1;
         n++;
      end
      checks++;
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL send_ready ready_out=%b required 1", ready_out);
      end
      ray_origin_in    = o;
      ray_direction_in = d;
      hcount_in        = h;
      vcount_in        = v;
      valid_in         = 1'b1;
      @(posedge clk_in); #1;
      valid_in = 1'b0;
   endtask

   // Waits for a result, compares it with the scoreboard head, optionally
   // stalls downstream for `hold` cycles (with a spurious SDF strobe), then
   // completes the output handshake.
   task automatic get_result(input string name, input int hold);
      int   n;
      int   lat_exp;
      exp_t e;
      n = 0;
      while (valid_out !== 1'b1 && n < 400) begin
         @(posedge clk_in); #1;
         n++;
      end
      checks++;
      if (valid_out !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout valid_out=%b required 1", name, valid_out);
         return;
      end
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s_unexpected result with empty scoreboard", name);
         return;
      end
      e = sb_q.pop_front();
      lat_exp = e.evals * (1 + mock_lat) + 1;
      checks++;
      if (n + 1 !== lat_exp) begin
         errors++;
         $display("FAIL %s_latency got=%0d required=%0d", name, n + 1, lat_exp);
      end
      checks++;
      if (hit_out !== e.hit) begin
         errors++;
         $display("FAIL %s_hit got=%b required=%b", name, hit_out, e.hit);
      end
      checks++;
      if (steps_out !== e.steps) begin
         errors++;
         $display("FAIL %s_steps got=%0d required=%0d", name, steps_out, e.steps);
      end
      checks++;
      if (color_out !== e.color) begin
         errors++;
         $display("FAIL %s_color got=%h required=%h", name, color_out, e.color);
      end
      checks++;
      if (hcount_out !== e.h || vcount_out !== e.v) begin
         errors++;
         $display("FAIL %s_tag got=%0d,%0d required=%0d,%0d", name, hcount_out, vcount_out, e.h, e.v);
      end
      checks++;
      if (sdf_point_out !== e.pt) begin
         errors++;
         $display("FAIL %s_point got=%h required=%h", name, sdf_point_out, e.pt);
      end
      for (int i = 0; i < hold; i++) begin
         spur_valid = (i == 3);
         spur_dist  = '0;
         @(posedge clk_in); #1;
         spur_valid = 1'b0;
         checks++;
         if (valid_out !== 1'b1 || ready_out !== 1'b0 || hit_out !== e.hit ||
             steps_out !== e.steps || color_out !== e.color ||
             hcount_out !== e.h || sdf_point_out !== e.pt) begin
            errors++;
            $display("FAIL %s_hold cycle=%0d valid=%b ready=%b hit=%b steps=%0d color=%h required valid=1 ready=0 hit=%b steps=%0d color=%h",
                     name, i, valid_out, ready_out, hit_out, steps_out, color_out, e.hit, e.steps, e.color);
         end
      end
      ready_in = 1'b1;
      @(posedge clk_in); #1;
      ready_in = 1'b0;
      exp_rays++;
      if (e.hit) exp_hits++;
      checks++;
      if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
         errors++;
         $display("FAIL %s_release valid_out=%b ready_out=%b required 0,1", name, valid_out, ready_out);
      end
      $display("RESULT %s h=%0d v=%0d hit=%b steps=%0d color=%h cycles=%0d",
               name, e.h, e.v, e.hit, e.steps, e.color, n + 1);
   endtask

   // ---------------- scenarios ----------------------------------------------
   task automatic test_reset();
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0 || sdf_valid_out !== 1'b0 ||
          hit_out !== 1'b0 || color_out !== '0 || steps_out !== '0 ||
          hcount_out !== '0 || vcount_out !== '0 || sdf_point_out !== '0) begin
         errors++;
         $display("FAIL reset_state ready=%b valid=%b sdf_valid=%b hit=%b color=%h steps=%0d h=%0d v=%0d pt=%h required 1,0,0,0,0,0,0,0,0",
                  ready_out, valid_out, sdf_valid_out, hit_out, color_out, steps_out, hcount_out, vcount_out, sdf_point_out);
      end
   endtask

   task automatic test_plane();
      mock_mode = 0;
      mock_lat  = 3;
      push_exp(11'd5, 10'd7, 1'b1, 2, 15, mkv(0, 0, FP_ONE), 2);
      send_ray(11'd5, 10'd7, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      get_result("plane", 0);
   endtask

   task automatic test_escape();
      set_table(FP_ONE * 6, 8, FP_ONE * 6);
      push_exp(11'd9, 10'd3, 1'b0, 1, 0, mkv(FP_ONE, FP_ONE, FP_ONE), 1);
      send_ray(11'd9, 10'd3, mkv(FP_ONE, FP_ONE, FP_ONE), mkv(0, 0, FP_ONE));
      get_result("escape", 0);
   endtask

   task automatic test_exhaust();
      set_table(HALF, 8, HALF);
      push_exp(11'd100, 10'd200, 1'b0, MAX_STEPS, 0, mkv(0, 0, HALF * 7), MAX_STEPS);
      send_ray(11'd100, 10'd200, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      get_result("exhaust", 0);
   endtask

   task automatic test_boundaries();
      set_table(EPS, 1, 0);
      push_exp(11'd1, 10'd1, 1'b1, 2, 15, mkv(0, 0, EPS), 2);
      send_ray(11'd1, 10'd1, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      get_result("eps_edge", 0);
      set_table(FP_FIVE, 1, 0);
      push_exp(11'd2, 10'd2, 1'b1, 2, 15, mkv(0, 0, FP_FIVE), 2);
      send_ray(11'd2, 10'd2, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      get_result("far_edge", 0);
   endtask

   task automatic test_shade_fast();
      mock_lat = 1;
      set_table(HALF, 5, 0);
      push_exp(11'd640, 10'd480, 1'b1, 6, 13, mkv(FP_ONE, HALF * 5, -FP_FIVE), 6);
      send_ray(11'd640, 10'd480, mkv(FP_ONE, 0, 0), mkv(0, FP_ONE, -2 * FP_ONE));
      get_result("shade_l1", 0);
      mock_lat = 3;
   endtask

   task automatic test_hold();
      mock_mode = 0;
      mock_lat  = 3;
      push_exp(11'h7FF, 10'h3FF, 1'b1, 2, 15, mkv(0, 0, FP_ONE), 2);
      send_ray(11'h7FF, 10'h3FF, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      get_result("hold", 10);
      // A stray response while idle must not start anything
      spur_valid = 1'b1;
      @(posedge clk_in); #1;
      spur_valid = 1'b0;
      @(posedge clk_in); #1;
      checks++;
      if (ready_out !== 1'b1 || sdf_valid_out !== 1'b0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL idle_spurious ready=%b sdf_valid=%b valid=%b required 1,0,0",
                  ready_out, sdf_valid_out, valid_out);
      end
   endtask

   task automatic test_reset_mid();
      mock_mode = 0;
      mock_lat  = 5;
      send_ray(11'd33, 10'd44, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      #1;
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0 || sdf_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ready=%b valid=%b sdf_valid=%b required 1,0,0",
                  ready_out, valid_out, sdf_valid_out);
      end
      @(posedge clk_in); #1;
      rst_in   = 1'b0;
      exp_rays = 0;
      exp_hits = 0;
`ifdef RAY_MARCH_STATS_EN
      checks++;
      if (rays_done_out !== 32'd0 || hits_done_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats rays=%0d hits=%0d required 0,0", rays_done_out, hits_done_out);
      end
`endif
      // Let the orphaned mock response land while idle
      repeat (8) begin
         @(posedge clk_in); #1;
      end
      checks++;
      if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_orphan ready=%b valid=%b required 1,0", ready_out, valid_out);
      end
      mock_lat = 3;
      push_exp(11'd12, 10'd34, 1'b1, 2, 15, mkv(0, 0, FP_ONE), 2);
      send_ray(11'd12, 10'd34, mkv(0, 0, 0), mkv(0, 0, FP_ONE));
      get_result("after_reset", 0);
   endtask

   task automatic test_stats();
`ifdef RAY_MARCH_STATS_EN
      checks++;
      if (rays_done_out !== 32'(exp_rays) || hits_done_out !== 32'(exp_hits)) begin
         errors++;
         $display("FAIL stats rays=%0d hits=%0d required %0d,%0d",
                  rays_done_out, hits_done_out, exp_rays, exp_hits);
      end
`endif
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d required 0", sb_q.size());
      end
   endtask

   initial begin
      rst_in           = 1'b1;
      valid_in         = 1'b0;
      ready_in         = 1'b0;
      ray_origin_in    = '0;
      ray_direction_in = '0;
      hcount_in        = '0;
      vcount_in        = '0;
      for (int i = 0; i < 8; i++) mock_table[i] = '0;
      repeat (3) @(posedge clk_in);
      #1;
      test_reset();
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      test_plane();
      test_escape();
      test_exhaust();
      test_boundaries();
      test_shade_fast();
      test_hold();
      test_reset_mid();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
